psg_sample_mixer: RTL and testbench

Downstream of the PSG. Consumes the three 8-bit log-DAC channel levels at PSG CE rate and builds a mono or stereo mix. Box-car decimates the mix by 2^DECIM_LOG2 CE ticks and removes DC with a one-pole high-pass. Emits signed 16-bit L/R samples with a one-cycle valid strobe to the codec/audio-out stage.

---
 rtl/psg_audio_pkg.sv | 46 ++++
 rtl/dc_block_hpf.sv | 41 ++++
 rtl/psg_sample_mixer.sv | 108 ++++++++++
 tb/tb_psg_sample_mixer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_audio_pkg.sv
// Shared widths, the stereo/mono mix helper and the output saturator
// for the PSG audio path.
package psg_audio_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int MIX_W       = 10;
  localparam int SCALE_SHIFT = 5;
  localparam int Y_W         = 18;
  localparam int X_W         = SAMPLE_W + 1;

  localparam logic signed [Y_W-1:0] SAT_HI = Y_W'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [Y_W-1:0] SAT_LO = ~SAT_HI;

  typedef struct packed {
    logic [MIX_W-1:0] l;
    logic [MIX_W-1:0] r;
  } mix_pair_t;

  // Stereo places A hard left and C hard right with B shared in the centre.
  function automatic mix_pair_t mix_levels(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c,
                                           input logic       stereo,
                                           input logic       mute);
    mix_pair_t m;
    m.l = '0;
    m.r = '0;
    if (!mute) begin
      if (stereo) begin
        m.l = (MIX_W'(a) << 1) + MIX_W'(b);
        m.r = (MIX_W'(c) << 1) + MIX_W'(b);
      end else begin
        m.l = MIX_W'(a) + MIX_W'(b) + MIX_W'(c);
        m.r = m.l;
      end
    end
    return m;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [Y_W-1:0] v);
    if (v > SAT_HI)      return SAMPLE_W'(SAT_HI);
    else if (v < SAT_LO) return SAMPLE_W'(SAT_LO);
    else                 return SAMPLE_W'(v);
  endfunction

endpackage

// File: rtl/dc_block_hpf.sv
// One-pole DC blocker, y = x - x_prev + y_prev - (y_prev >>> K), stepped once per load.
// Filter state advances in bypass too, so toggling bypass never glitches.
module dc_block_hpf
  import psg_audio_pkg::*;
#(
  parameter int K = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       load,
  input  logic signed [X_W-1:0]      x,
  input  logic                       bypass,
  output logic signed [SAMPLE_W-1:0] y_out
);

  logic signed [X_W-1:0] x_prev;
  logic signed [Y_W-1:0] y_prev;
  logic signed [Y_W-1:0] x_ext;
  logic signed [Y_W-1:0] xp_ext;
  logic signed [Y_W-1:0] y_next;

  // NOTE: each always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    x_ext  = {{(Y_W-X_W){x[X_W-1]}}, x};
    xp_ext = {{(Y_W-X_W){x_prev[X_W-1]}}, x_prev};
    y_next = x_ext - xp_ext + y_prev - (y_prev >>> K);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_prev <= '0;
      y_prev <= '0;
      y_out  <= '0;
    end else if (load) begin
      x_prev <= x;
      y_prev <= y_next;
      y_out  <= bypass ? SAMPLE_W'(x) : sat_sample(y_next);
    end
  end

endmodule

// File: rtl/psg_sample_mixer.sv
// PSG channel mixer: per-CE mono/stereo mix, box-car decimation by 2^DECIM_LOG2 ticks,
// DC blocking, and signed 16-bit L/R samples with a one-cycle valid strobe.
module psg_sample_mixer
  import psg_audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 5,  // legal 2..8; keeps windows longer than the pipeline
  parameter int HPF_SHIFT  = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CE,
  input  logic [7:0]          CH_A,
  input  logic [7:0]          CH_B,
  input  logic [7:0]          CH_C,
  input  logic                STEREO,
  input  logic                MUTE,
  input  logic                DC_BYPASS,
  output logic [SAMPLE_W-1:0] SAMPLE_L,
  output logic [SAMPLE_W-1:0] SAMPLE_R,
  output logic                SAMPLE_VALID
);

  localparam int ACC_W = MIX_W + DECIM_LOG2;

  mix_pair_t             mix;
  logic [DECIM_LOG2-1:0] tick_cnt;
  logic [ACC_W-1:0]      acc_l, acc_r;
  logic [ACC_W-1:0]      sum_l, sum_r;
  logic [ACC_W-1:0]      win_l, win_r;
  logic                  win_vld;
  logic [MIX_W-1:0]      avg_l, avg_r;
  logic                  avg_vld;
  logic signed [X_W-1:0] x_l, x_r;

  always_comb begin
    mix   = mix_levels(CH_A, CH_B, CH_C, STEREO, MUTE);
    sum_l = acc_l + ACC_W'(mix.l);
    sum_r = acc_r + ACC_W'(mix.r);
  end

  // The closing tick's own mix goes into the window total while the
  // accumulators restart at zero, so every tick lands in exactly one window.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_cnt <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      win_l    <= '0;
      win_r    <= '0;
      win_vld  <= 1'b0;
    end else begin
      win_vld <= 1'b0;
      if (CE) begin
        tick_cnt <= tick_cnt + DECIM_LOG2'(1);
        if (&tick_cnt) begin
          win_l   <= sum_l;
          win_r   <= sum_r;
          acc_l   <= '0;
          acc_r   <= '0;
          win_vld <= 1'b1;
        end else begin
          acc_l <= sum_l;
          acc_r <= sum_r;
        end
      end
    end
  end

  // Pipeline is CLK-timed so an in-flight sample completes even with CE low.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      avg_l        <= '0;
      avg_r        <= '0;
      avg_vld      <= 1'b0;
      SAMPLE_VALID <= 1'b0;
    end else begin
      avg_vld      <= win_vld;
      SAMPLE_VALID <= avg_vld;
      if (win_vld) begin
        avg_l <= MIX_W'(win_l >> DECIM_LOG2);
        avg_r <= MIX_W'(win_r >> DECIM_LOG2);
      end
    end
  end

  assign x_l = X_W'(avg_l) << SCALE_SHIFT;
  assign x_r = X_W'(avg_r) << SCALE_SHIFT;

  dc_block_hpf #(.K(HPF_SHIFT)) u_hpf_l (
    .CLK    (CLK),
    .RESET  (RESET),
    .load   (avg_vld),
    .x      (x_l),
    .bypass (DC_BYPASS),
    .y_out  (SAMPLE_L)
  );

  dc_block_hpf #(.K(HPF_SHIFT)) u_hpf_r (
    .CLK    (CLK),
    .RESET  (RESET),
    .load   (avg_vld),
    .x      (x_r),
    .bypass (DC_BYPASS),
    .y_out  (SAMPLE_R)
  );

endmodule

// File: tb/tb_psg_sample_mixer.sv
// Bench for psg_sample_mixer: a DECIM_LOG2=5 instance driven at CE/4 and a
// DECIM_LOG2=2 instance driven with CE continuous, both against a queue scoreboard.
module tb_psg_sample_mixer;

  localparam int K = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ce5, ce2;
  logic [7:0]  ch_a, ch_b, ch_c;
  logic        stereo, mute, bypass;
  logic [15:0] l5, r5, l2, r2;
  logic        v5, v2;

  always #5 CLK = ~CLK;

  psg_sample_mixer #(.DECIM_LOG2(5), .HPF_SHIFT(K)) dut5 (
    .CLK(CLK), .RESET(RESET), .CE(ce5),
    .CH_A(ch_a), .CH_B(ch_b), .CH_C(ch_c),
    .STEREO(stereo), .MUTE(mute), .DC_BYPASS(bypass),
    .SAMPLE_L(l5), .SAMPLE_R(r5), .SAMPLE_VALID(v5)
  );

  psg_sample_mixer #(.DECIM_LOG2(2), .HPF_SHIFT(K)) dut2 (
    .CLK(CLK), .RESET(RESET), .CE(ce2),
    .CH_A(ch_a), .CH_B(ch_b), .CH_C(ch_c),
    .STEREO(stereo), .MUTE(mute), .DC_BYPASS(bypass),
    .SAMPLE_L(l2), .SAMPLE_R(r2), .SAMPLE_VALID(v2)
  );

  typedef struct { int l; int r; } exp_t;
  typedef struct {
    logic [7:0] a, b, c;
    bit         st, mu;
    int         el, er;
  } vec_t;

  exp_t q5[$];
  exp_t q2[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state, index 0 = dut5, 1 = dut2.
  int dlog[2] = '{5, 2};
  int m_sum_l[2], m_sum_r[2], m_ticks[2];
  int m_xp_l[2], m_yp_l[2], m_xp_r[2], m_yp_r[2];
  bit ovr = 1'b0;
  int ovr_l, ovr_r;

  int cyc   = 0;
  int last2 = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat16(input int y);
    if (y > 32767)  return 32767;
    if (y < -32768) return -32768;
    return y;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sum_l[i] = 0; m_sum_r[i] = 0; m_ticks[i] = 0;
      m_xp_l[i]  = 0; m_yp_l[i]  = 0; m_xp_r[i]  = 0; m_yp_r[i] = 0;
    end
    q5.delete();
    q2.delete();
  endtask

  // Called once for every CE tick a DUT will see, with the inputs it will see.
  task automatic model_step(input int m);
    int   ml, mr, xl, xr, yl, yr;
    exp_t e;
    if (mute) begin
      ml = 0; mr = 0;
    end else if (stereo) begin
      ml = 2 * ch_a + ch_b;
      mr = 2 * ch_c + ch_b;
    end else begin
      ml = ch_a + ch_b + ch_c;
      mr = ml;
    end
    m_sum_l[m] += ml;
    m_sum_r[m] += mr;
    m_ticks[m]++;
    if (m_ticks[m] == (1 << dlog[m])) begin
      xl = (m_sum_l[m] >> dlog[m]) * 32;
      xr = (m_sum_r[m] >> dlog[m]) * 32;
      yl = xl - m_xp_l[m] + m_yp_l[m] - (m_yp_l[m] >>> K);
      yr = xr - m_xp_r[m] + m_yp_r[m] - (m_yp_r[m] >>> K);
      m_xp_l[m] = xl; m_yp_l[m] = yl;
      m_xp_r[m] = xr; m_yp_r[m] = yr;
      e.l = bypass ? xl : sat16(yl);
      e.r = bypass ? xr : sat16(yr);
      if (ovr) begin
        e.l = ovr_l;
        e.r = ovr_r;
      end
      if (m == 0) q5.push_back(e);
      else        q2.push_back(e);
      m_sum_l[m] = 0; m_sum_r[m] = 0; m_ticks[m] = 0;
    end
  endtask

  // One CE pulse to dut5, then `gap` idle cycles (gap=2 gives CE every 4 CLK).
  task automatic ce_tick5(input int gap);
    @(negedge CLK);
    ce5 = 1'b1;
    model_step(0);
    @(negedge CLK);
    ce5 = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic window5();
    repeat (32) ce_tick5(2);
  endtask

  // CE held high for n consecutive CLKs on dut2; rnd picks fresh channel levels each tick.
  task automatic burst2(input int n, input bit rnd);
    last2 = -1;
    @(negedge CLK);
    ce2 = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        ch_a = 8'($urandom_range(0, 255));
        ch_b = 8'($urandom_range(0, 255));
        ch_c = 8'($urandom_range(0, 255));
      end
      model_step(1);
      @(negedge CLK);
    end
    ce2 = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    exp_t e5, e2;
    if (v5) begin
      if (q5.size() == 0) check("d5 unexpected strobe", 1, 0);
      else begin
        e5 = q5.pop_front();
        check("d5 SAMPLE_L", int'($signed(l5)), e5.l);
        check("d5 SAMPLE_R", int'($signed(r5)), e5.r);
      end
    end
    if (v2) begin
      if (q2.size() == 0) check("d2 unexpected strobe", 1, 0);
      else begin
        e2 = q2.pop_front();
        check("d2 SAMPLE_L", int'($signed(l2)), e2.l);
        check("d2 SAMPLE_R", int'($signed(r2)), e2.r);
      end
      if (last2 >= 0) check("d2 strobe spacing", cyc - last2, 4);
      last2 = cyc;
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 24480, 24480};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 16320, 0};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 8160,  8160};
    vecs[3] = '{8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 0,     16320};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 0,     0};
    vecs[5] = '{8'h80, 8'h40, 8'h01, 1'b0, 1'b0, 6176,  6176};
    vecs[6] = '{8'h10, 8'h20, 8'h30, 1'b1, 1'b0, 2048,  4096};

    RESET = 1'b1; ce5 = 1'b0; ce2 = 1'b0;
    ch_a = '0; ch_b = '0; ch_c = '0;
    stereo = 1'b0; mute = 1'b0; bypass = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset d5 SAMPLE_L", int'(l5), 0);
    check("reset d5 SAMPLE_R", int'(r5), 0);
    check("reset d5 SAMPLE_VALID", int'(v5), 0);
    check("reset d2 SAMPLE_VALID", int'(v2), 0);
    RESET = 1'b0;

    // Silence: strobe exactly 2 CLK after the 32nd tick edge, one CLK wide.
    repeat (31) ce_tick5(2);
    @(negedge CLK);
    ce5 = 1'b1;
    model_step(0);
    @(negedge CLK);
    ce5 = 1'b0;
    check("t1 valid at T", int'(v5), 0);
    @(negedge CLK);
    check("t1 valid at T+1", int'(v5), 0);
    @(negedge CLK);
    check("t1 valid at T+2", int'(v5), 1);
    @(negedge CLK);
    check("t1 valid at T+3", int'(v5), 0);
    repeat (2) @(negedge CLK);

    // Constant-level windows with the DC blocker bypassed.
    bypass = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ch_a = vecs[i].a; ch_b = vecs[i].b; ch_c = vecs[i].c;
      stereo = vecs[i].st; mute = vecs[i].mu;
      ovr = 1'b1; ovr_l = vecs[i].el; ovr_r = vecs[i].er;
      window5();
      ovr = 1'b0;
    end
    mute = 1'b0;

    // Half-window level: truncating average 127 -> 4064.
    stereo = 1'b0; ch_b = '0; ch_c = '0;
    ch_a = 8'hFF; repeat (16) ce_tick5(2);
    ch_a = 8'h00; repeat (16) ce_tick5(2);

    // STEREO flipped mid-window only affects later ticks.
    ch_a = 8'hFF; ch_b = 8'h00; ch_c = 8'h40;
    stereo = 1'b0; repeat (16) ce_tick5(2);
    stereo = 1'b1; repeat (16) ce_tick5(2);

    // DC blocker: step up, decay, a bypassed window mid-decay, step back down.
    bypass = 1'b0; stereo = 1'b0;
    ch_a = '0; ch_b = '0; ch_c = '0;
    repeat (2) window5();
    ch_a = 8'hFF; ch_b = 8'hFF; ch_c = 8'hFF;
    repeat (4) window5();
    bypass = 1'b1; window5();
    bypass = 1'b0; window5();
    ch_a = '0; ch_b = '0; ch_c = '0;
    repeat (3) window5();

    // Reset 20 ticks into a window: that window never strobes.
    ch_a = 8'hFF; ch_b = 8'hFF; ch_c = 8'hFF;
    repeat (20) ce_tick5(2);
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
    window5();
    repeat (4) @(negedge CLK);
    check("d5 queue drained after reset window", q5.size(), 0);

    // DECIM_LOG2=2 with CE high every CLK.
    bypass = 1'b1; stereo = 1'b0;
    ch_a = 8'hFF; ch_b = 8'hFF; ch_c = 8'hFF;
    burst2(8, 1'b0);
    stereo = 1'b1;
    ch_a = 8'h55; ch_b = 8'h0F; ch_c = 8'hAA;
    burst2(12, 1'b0);
    burst2(16, 1'b1);
    bypass = 1'b0; stereo = 1'b0;
    burst2(16, 1'b1);

    repeat (6) @(negedge CLK);
    check("d5 queue drained", q5.size(), 0);
    check("d2 queue drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
